// File: rtl/cpu_pkg.sv
// Shared types and constants for the in-order MIPS core pipeline.
package cpu_pkg;

  localparam int unsigned BE_W = 4;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LWL = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load data alignment and GPR byte enables, including LWL/LWR merge.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]      load_type,
  input  logic [1:0]      a,
  input  logic [31:0]     m,
  input  logic [31:0]     rt_data,
  output logic [31:0]     data,
  output logic [BE_W-1:0] byte_en
);

  logic [31:0] m_right;
  logic [31:0] m_left;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign m_right  = m >> {a, 3'b000};
  assign m_left   = m << {~a, 3'b000};
  assign sel_byte = m_right[7:0];
  assign sel_half = a[1] ? m[31:16] : m[15:0];

  always_comb begin
    data    = m;
    byte_en = '1;
    case (load_type)
      LT_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU: data = {24'h0, sel_byte};
      LT_LH:  data = {{16{sel_half[15]}}, sel_half};
      LT_LHU: data = {16'h0, sel_half};
      LT_LWL: begin
        byte_en = 4'b1111 << ~a;
        for (int unsigned i = 0; i < BE_W; i++)
          data[8*i +: 8] = byte_en[i] ? m_left[8*i +: 8] : rt_data[8*i +: 8];
      end
      LT_LWR: begin
        byte_en = 4'b1111 >> a;
        for (int unsigned i = 0; i < BE_W; i++)
          data[8*i +: 8] = byte_en[i] ? m_right[8*i +: 8] : rt_data[8*i +: 8];
      end
      default: data = m;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access completion stage and MEM/WB register: waits for load data,
// aligns it, and handles flush while a memory response is still owed.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RA = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          exmem_valid,
  input  logic [RA-1:0] exmem_rd_addr,
  input  logic [3:0]    exmem_byte_en,
  input  logic [DW-1:0] exmem_result,
  input  logic          exmem_is_load,
  input  logic [2:0]    exmem_load_type,
  input  logic [DW-1:0] exmem_rt_data,
  input  logic [4:0]    exmem_cp0_dst_addr,
  input  logic          exmem_cp0_w_en_out,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_data_ok,
  input  logic          flush,
  output logic          mem_stall,
  output logic [RA-1:0] memwb_rd_addr,
  output logic [3:0]    memwb_byte_en,
  output logic [DW-1:0] memwb_data,
  output logic [4:0]    memwb_cp0_dst_addr,
  output logic          memwb_cp0_w_en
);

  mem_state_t state_q, state_d;
  logic       ld_req;
  logic       capture_alu;
  logic       capture_ld;
  logic [31:0]     al_data;
  logic [BE_W-1:0] al_be;

  assign ld_req = exmem_valid & exmem_is_load;

  load_align u_load_align (
    .load_type (exmem_load_type),
    .a         (exmem_result[1:0]),
    .m         (dmem_rdata),
    .rt_data   (exmem_rt_data),
    .data      (al_data),
    .byte_en   (al_be)
  );

  always_comb begin
    state_d     = state_q;
    capture_alu = 1'b0;
    capture_ld  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && ld_req) begin
          if (dmem_data_ok) capture_ld = 1'b1;
          else              state_d    = S_WAIT;
        end else if (!flush && exmem_valid) begin
          capture_alu = 1'b1;
        end
      end
      S_WAIT: begin
        // A flush racing the response drops it; otherwise the response is still owed.
        if (flush) begin
          state_d = dmem_data_ok ? S_IDLE : S_DRAIN;
        end else if (dmem_data_ok) begin
          capture_ld = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (dmem_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_stall = (state_q != S_IDLE) |
                     (ld_req & ~dmem_data_ok & ~flush);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q            <= S_IDLE;
      memwb_rd_addr      <= '0;
      memwb_byte_en      <= '0;
      memwb_data         <= '0;
      memwb_cp0_dst_addr <= '0;
      memwb_cp0_w_en     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_alu) begin
        memwb_rd_addr      <= exmem_rd_addr;
        memwb_byte_en      <= exmem_byte_en;
        memwb_data         <= exmem_result;
        memwb_cp0_dst_addr <= exmem_cp0_dst_addr;
        memwb_cp0_w_en     <= exmem_cp0_w_en_out;
      end else if (capture_ld) begin
        memwb_rd_addr      <= exmem_rd_addr;
        memwb_byte_en      <= (|exmem_byte_en) ? al_be : '0;
        memwb_data         <= al_data;
        memwb_cp0_dst_addr <= exmem_cp0_dst_addr;
        memwb_cp0_w_en     <= exmem_cp0_w_en_out;
      end else begin
        memwb_rd_addr      <= '0;
        memwb_byte_en      <= '0;
        memwb_data         <= '0;
        memwb_cp0_dst_addr <= '0;
        memwb_cp0_w_en     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exmem_valid;
  logic [4:0]  exmem_rd_addr;
  logic [3:0]  exmem_byte_en;
  logic [31:0] exmem_result;
  logic        exmem_is_load;
  logic [2:0]  exmem_load_type;
  logic [31:0] exmem_rt_data;
  logic [4:0]  exmem_cp0_dst_addr;
  logic        exmem_cp0_w_en_out;
  logic [31:0] dmem_rdata;
  logic        dmem_data_ok;
  logic        flush;
  logic        mem_stall;
  logic [4:0]  memwb_rd_addr;
  logic [3:0]  memwb_byte_en;
  logic [31:0] memwb_data;
  logic [4:0]  memwb_cp0_dst_addr;
  logic        memwb_cp0_w_en;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DW(32), .RA(5)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .exmem_valid        (exmem_valid),
    .exmem_rd_addr      (exmem_rd_addr),
    .exmem_byte_en      (exmem_byte_en),
    .exmem_result       (exmem_result),
    .exmem_is_load      (exmem_is_load),
    .exmem_load_type    (exmem_load_type),
    .exmem_rt_data      (exmem_rt_data),
    .exmem_cp0_dst_addr (exmem_cp0_dst_addr),
    .exmem_cp0_w_en_out (exmem_cp0_w_en_out),
    .dmem_rdata         (dmem_rdata),
    .dmem_data_ok       (dmem_data_ok),
    .flush              (flush),
    .mem_stall          (mem_stall),
    .memwb_rd_addr      (memwb_rd_addr),
    .memwb_byte_en      (memwb_byte_en),
    .memwb_data         (memwb_data),
    .memwb_cp0_dst_addr (memwb_cp0_dst_addr),
    .memwb_cp0_w_en     (memwb_cp0_w_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic [2:0] lt,
                        input logic [4:0] rd, input logic [3:0] be,
                        input logic [31:0] res, input logic [31:0] rt);
    exmem_valid     = v;
    exmem_is_load   = ld;
    exmem_load_type = lt;
    exmem_rd_addr   = rd;
    exmem_byte_en   = be;
    exmem_result    = res;
    exmem_rt_data   = rt;
  endtask

  initial begin
    resetn = 1'b0;
    set_op(1'b0, 1'b0, LT_LW, 5'd0, 4'h0, 32'h0, 32'h0);
    exmem_cp0_dst_addr = 5'd0;
    exmem_cp0_w_en_out = 1'b0;
    dmem_rdata   = 32'h0;
    dmem_data_ok = 1'b0;
    flush        = 1'b0;
    tick(); tick();
    chk("rst_rd", 32'(memwb_rd_addr), 32'd0);
    chk("rst_be", 32'(memwb_byte_en), 32'd0);
    chk("rst_data", memwb_data, 32'h0);
    chk("rst_cp0dst", 32'(memwb_cp0_dst_addr), 32'd0);
    chk("rst_cp0we", 32'(memwb_cp0_w_en), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    resetn = 1'b1;

    // ALU op
    set_op(1'b1, 1'b0, LT_LW, 5'd5, 4'hF, 32'h1234_5678, 32'h0);
    settle();
    chk("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("alu_rd", 32'(memwb_rd_addr), 32'd5);
    chk("alu_be", 32'(memwb_byte_en), 32'hF);
    chk("alu_data", memwb_data, 32'h1234_5678);

    // MTC0-style CP0 write passes through
    set_op(1'b1, 1'b0, LT_LW, 5'd0, 4'h0, 32'hA5A5_0000, 32'h0);
    exmem_cp0_dst_addr = 5'd12;
    exmem_cp0_w_en_out = 1'b1;
    tick();
    chk("cp0_dst", 32'(memwb_cp0_dst_addr), 32'd12);
    chk("cp0_we", 32'(memwb_cp0_w_en), 32'd1);
    chk("cp0_be0", 32'(memwb_byte_en), 32'd0);
    exmem_cp0_dst_addr = 5'd0;
    exmem_cp0_w_en_out = 1'b0;

    // Invalid instruction gives a bubble
    set_op(1'b0, 1'b0, LT_LW, 5'd5, 4'hF, 32'h1234_5678, 32'h0);
    tick();
    chk("inv_be", 32'(memwb_byte_en), 32'd0);

    // LB a=2, data_ok after 3 stall cycles
    set_op(1'b1, 1'b1, LT_LB, 5'd8, 4'hF, 32'h1000_0002, 32'h0);
    dmem_rdata = 32'h0080_0000;
    settle();
    chk("lb_stall0", 32'(mem_stall), 32'd1);
    tick();
    chk("lb_stall1", 32'(mem_stall), 32'd1);
    chk("lb_bub1", 32'(memwb_byte_en), 32'd0);
    dmem_data_ok = 1'b0;
    tick();
    dmem_data_ok = 1'b1;
    settle();
    chk("lb_stall2", 32'(mem_stall), 32'd1);
    chk("lb_bub2", 32'(memwb_byte_en), 32'd0);
    tick();
    set_op(1'b0, 1'b0, LT_LW, 5'd0, 4'h0, 32'h0, 32'h0);
    dmem_data_ok = 1'b0;
    settle();
    chk("lb_rd", 32'(memwb_rd_addr), 32'd8);
    chk("lb_be", 32'(memwb_byte_en), 32'hF);
    chk("lb_data", memwb_data, 32'hFFFF_FF80);
    chk("lb_stall_end", 32'(mem_stall), 32'd0);

    // LWL a=1, same-cycle data_ok
    set_op(1'b1, 1'b1, LT_LWL, 5'd9, 4'hF, 32'h2000_0001, 32'h1122_3344);
    dmem_rdata   = 32'hAABB_CCDD;
    dmem_data_ok = 1'b1;
    settle();
    chk("lwl_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("lwl_be", 32'(memwb_byte_en), 32'hC);
    chk("lwl_data", memwb_data, 32'hCCDD_3344);

    // LWR a=3
    set_op(1'b1, 1'b1, LT_LWR, 5'd9, 4'hF, 32'h2000_0003, 32'h1122_3344);
    tick();
    chk("lwr_be", 32'(memwb_byte_en), 32'h1);
    chk("lwr_data", memwb_data, 32'h1122_33AA);

    // LH / LHU / LBU on a=2 / a=3
    dmem_rdata = 32'h8001_7F42;
    set_op(1'b1, 1'b1, LT_LH, 5'd3, 4'hF, 32'h0000_0002, 32'h0);
    tick();
    chk("lh_data", memwb_data, 32'hFFFF_8001);
    set_op(1'b1, 1'b1, LT_LHU, 5'd3, 4'hF, 32'h0000_0002, 32'h0);
    tick();
    chk("lhu_data", memwb_data, 32'h0000_8001);
    set_op(1'b1, 1'b1, LT_LBU, 5'd3, 4'hF, 32'h0000_0003, 32'h0);
    tick();
    chk("lbu_data", memwb_data, 32'h0000_0080);

    // Load to rd=0 still completes but writes nothing
    set_op(1'b1, 1'b1, LT_LW, 5'd0, 4'h0, 32'h0000_0000, 32'h0);
    tick();
    chk("ld_rd0_be", 32'(memwb_byte_en), 32'd0);

    // Flush in WAIT -> DRAIN, then discard the next response
    set_op(1'b1, 1'b1, LT_LW, 5'd4, 4'hF, 32'h0000_0010, 32'h0);
    dmem_data_ok = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("drain_stall", 32'(mem_stall), 32'd1);
    chk("drain_be", 32'(memwb_byte_en), 32'd0);
    dmem_rdata   = 32'hDEAD_BEEF;
    dmem_data_ok = 1'b1;
    tick();
    chk("drain_disc_be", 32'(memwb_byte_en), 32'd0);
    dmem_data_ok = 1'b0;
    set_op(1'b1, 1'b0, LT_LW, 5'd7, 4'hF, 32'hCAFE_F00D, 32'h0);
    settle();
    chk("post_drain_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("post_drain_rd", 32'(memwb_rd_addr), 32'd7);
    chk("post_drain_data", memwb_data, 32'hCAFE_F00D);

    // Reset during WAIT
    set_op(1'b1, 1'b1, LT_LW, 5'd6, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    chk("wait_stall", 32'(mem_stall), 32'd1);
    resetn = 1'b0;
    set_op(1'b0, 1'b0, LT_LW, 5'd0, 4'h0, 32'h0, 32'h0);
    tick();
    resetn = 1'b1;
    chk("rstw_stall", 32'(mem_stall), 32'd0);
    chk("rstw_be", 32'(memwb_byte_en), 32'd0);
    chk("rstw_rd", 32'(memwb_rd_addr), 32'd0);
    chk("rstw_data", memwb_data, 32'h0);

    // Flush and data_ok in the same WAIT cycle
    set_op(1'b1, 1'b1, LT_LW, 5'd6, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    flush        = 1'b1;
    dmem_data_ok = 1'b1;
    tick();
    flush        = 1'b0;
    dmem_data_ok = 1'b0;
    set_op(1'b0, 1'b0, LT_LW, 5'd0, 4'h0, 32'h0, 32'h0);
    settle();
    chk("fdok_be", 32'(memwb_byte_en), 32'd0);
    chk("fdok_idle", 32'(mem_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1);
  end

endmodule
